// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles, memory-wait freezes,
// branch flushes. Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_rw,
    input  logic       ex_mem_read,
    input  logic       mem_req_valid,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_bubble,
    output logic       ex_mem_stall,
    output logic       mem_wb_bubble,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

    state_e           state_q;
    logic [WaitW-1:0] wait_cnt_q;
    logic             timeout_q;

    logic mem_hold;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic lu_cond;
    logic lu_stall;
    logic lu_proto_err;

    assign mem_hold = mem_req_valid & ~mem_ready;
    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
    assign load_use = ex_mem_read & ex_rw & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);

    assign lu_cond  = load_use & ~branch_taken & ~mem_hold;
    // The bubble inserted last cycle sits in EX now, so a second stall is never issued.
    assign lu_stall     = lu_cond & (state_q != StLuStall);
    assign lu_proto_err = lu_cond & (state_q == StLuStall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (mem_hold) begin
                state_q <= StMemWait;
            end else if (lu_stall) begin
                state_q <= StLuStall;
            end else begin
                state_q <= StRun;
            end

            if (mem_hold) begin
                if (wait_cnt_q != TimeoutVal) begin
                    wait_cnt_q <= wait_cnt_q + WaitW'(1);
                end
                if (wait_cnt_q >= TimeoutVal - WaitW'(1)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            mem_timeout = timeout_q;
            if (mem_hold) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    lu_proto_chk: assert property (@(posedge clk) disable iff (!rst_n) !lu_proto_err);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] mwait_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
            mwait_q <= '0;
        end else begin
            if (lu_stall) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (branch_taken & ~mem_hold) begin
                flush_q <= flush_q + CNT_W'(1);
            end
            if (mem_hold) begin
                mwait_q <= mwait_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles    = rst_n ? stall_q : '0;
    assign flush_count     = rst_n ? flush_q : '0;
    assign mem_wait_cycles = rst_n ? mwait_q : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic, all
// compared against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned TO = 6;
    localparam int unsigned CW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mem_read;
    logic       mem_req_valid;
    logic       mem_ready;
    logic       branch_taken;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_bubble;
    logic       ex_mem_stall;
    logic       mem_wb_bubble;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic [CW-1:0] mem_wait_cycles;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_rw        (ex_rw),
        .ex_mem_read  (ex_mem_read),
        .mem_req_valid(mem_req_valid),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_wait_cycles(mem_wait_cycles),
`endif
        .mem_timeout  (mem_timeout)
    );

    // Output vector: {pc, if_id_stall, flush, id_ex_stall, bubble, ex_mem, mem_wb, timeout}
    localparam logic [7:0] Freeze = 8'hD6;
    localparam logic [7:0] Flush  = 8'h28;
    localparam logic [7:0] LuStl  = 8'hC8;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    bit          m_prev_lu;
    int unsigned m_hold_run;
    bit          m_to;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;
    logic [CW-1:0] m_mwait;
    logic [7:0]  last_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // True when the ID instruction reads a non-zero register that the EX load will write.
    function automatic bit ref_load_use();
        int reads[$];
        if (!(id_valid && ex_mem_read && ex_rw) || ex_rd == 5'd0) return 1'b0;
        if (id_uses_rs1) reads.push_back(int'(id_rs1));
        if (id_uses_rs2) reads.push_back(int'(id_rs2));
        foreach (reads[i]) if (reads[i] == int'(ex_rd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_hold();
        return mem_req_valid && !mem_ready;
    endfunction

    function automatic bit ref_lu_stall();
        return !ref_hold() && !branch_taken && ref_load_use() && !m_prev_lu;
    endfunction

    function automatic logic [7:0] expect_out();
        logic [7:0] v;
        if (!rst_n) return 8'h00;
        if (ref_hold()) v = Freeze;
        else if (branch_taken) v = Flush;
        else if (ref_lu_stall()) v = LuStl;
        else v = 8'h00;
        v[0] = m_to;
        return v;
    endfunction

    task automatic model_clock();
        if (!rst_n) begin
            m_prev_lu  = 1'b0;
            m_hold_run = 0;
            m_to       = 1'b0;
            m_stall    = '0;
            m_flush    = '0;
            m_mwait    = '0;
        end else begin
            if (ref_lu_stall()) m_stall = m_stall + 1;
            if (!ref_hold() && branch_taken) m_flush = m_flush + 1;
            if (ref_hold()) m_mwait = m_mwait + 1;
            m_prev_lu = ref_lu_stall();
            if (ref_hold()) begin
                if (m_hold_run < TO) m_hold_run++;
                if (m_hold_run == TO) m_to = 1'b1;
            end else begin
                m_hold_run = 0;
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs sampled 1 ns later, model advanced at posedge.
    task automatic cycle(input string tag);
        #1;
        last_obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
                    ex_mem_stall, mem_wb_bubble, mem_timeout};
        check(tag, 32'(last_obs), 32'(expect_out()));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_stall_cnt"}, stall_cycles, rst_n ? m_stall : '0);
        check({tag, "_flush_cnt"}, flush_count, rst_n ? m_flush : '0);
        check({tag, "_mwait_cnt"}, mem_wait_cycles, rst_n ? m_mwait : '0);
`endif
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_rw = 0; ex_mem_read = 0;
        mem_req_valid = 0; mem_ready = 0; branch_taken = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        ex_rd = rd; ex_rw = 1; ex_mem_read = 1;
        id_valid = 1; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    task automatic ex_bubble();
        ex_rd = 0; ex_rw = 0; ex_mem_read = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_prev_lu = 0; m_hold_run = 0; m_to = 0;
        m_stall = '0; m_flush = '0; m_mwait = '0;
        @(negedge clk);

        // Reset forces outputs low even with every hazard present.
        set_load_use(5'd5, 5'd5, 5'd7);
        mem_req_valid = 1; branch_taken = 1;
        cycle("reset_a");
        cycle("reset_b");
        check("reset_out", 32'(last_obs), 32'h0);
        rst_n = 1;
        idle();
        cycle("idle");
        check("idle_out", 32'(last_obs), 32'h0);

        // lw x5 ; add x6,x5,x7
        set_load_use(5'd5, 5'd5, 5'd7);
        cycle("lu_c0");
        check("lu_stall", 32'(last_obs), 32'(LuStl));
        ex_bubble();
        cycle("lu_c1");
        check("lu_release", 32'(last_obs), 32'h0);

        // Same source register twice: one bubble only.
        set_load_use(5'd5, 5'd5, 5'd5);
        cycle("dup_c0");
        check("dup_stall", 32'(last_obs), 32'(LuStl));
        ex_bubble();
        cycle("dup_c1");
        check("dup_release", 32'(last_obs), 32'h0);

        // x0 destination, and rs2 match without use.
        set_load_use(5'd0, 5'd0, 5'd0);
        cycle("x0");
        check("x0_no_stall", 32'(last_obs), 32'h0);
        set_load_use(5'd5, 5'd3, 5'd5);
        id_uses_rs2 = 0;
        cycle("nouse");
        check("nouse_no_stall", 32'(last_obs), 32'h0);

        // Five wait cycles then completion.
        idle();
        mem_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cycle("mw_hold");
            check("mw_freeze", 32'(last_obs), 32'(Freeze));
        end
        mem_ready = 1;
        cycle("mw_ready");
        check("mw_release", 32'(last_obs), 32'h0);

        // Timeout: hold past TO wait cycles; flag sticks after completion.
        mem_ready = 0;
        for (int i = 0; i < TO + 2; i++) begin
            cycle("to_hold");
            check("to_freeze", 32'(last_obs), (i < int'(TO)) ? 32'(Freeze) : 32'(Freeze | 8'h01));
        end
        mem_ready = 1;
        cycle("to_ready");
        check("to_sticky_release", 32'(last_obs), 32'h01);
        idle();
        cycle("to_idle");
        check("to_sticky_idle", 32'(last_obs), 32'h01);
        rst_n = 0;
        cycle("to_rst");
        check("to_rst_out", 32'(last_obs), 32'h0);
        rst_n = 1;
        cycle("to_after_rst");
        check("to_cleared", 32'(last_obs), 32'h0);

        // Branch beats load-use.
        set_load_use(5'd9, 5'd9, 5'd1);
        branch_taken = 1;
        cycle("br_lu");
        check("br_over_lu", 32'(last_obs), 32'(Flush));
        // Memory hold beats branch; branch flushes in the release cycle.
        mem_req_valid = 1; mem_ready = 0;
        cycle("br_hold_a");
        check("hold_over_br", 32'(last_obs), 32'(Freeze));
        cycle("br_hold_b");
        mem_ready = 1;
        cycle("br_release");
        check("br_release_flush", 32'(last_obs), 32'(Flush));
        // Load-use pending at memory release stalls in the release cycle.
        branch_taken = 0; mem_ready = 0;
        cycle("lu_hold");
        mem_ready = 1;
        cycle("lu_mem_release");
        check("lu_after_mem", 32'(last_obs), 32'(LuStl));
        idle();
        cycle("lu_mem_done");

        // Reset during wait cycle 3 clears the wait counter.
        mem_req_valid = 1;
        cycle("rm_hold1");
        cycle("rm_hold2");
        rst_n = 0;
        cycle("rm_rst");
        check("rm_rst_out", 32'(last_obs), 32'h0);
        rst_n = 1;
        for (int i = 0; i < TO - 1; i++) begin
            cycle("rm_hold");
            check("rm_no_timeout", 32'(last_obs), 32'(Freeze));
        end
        mem_ready = 1;
        cycle("rm_release");
        check("rm_release_out", 32'(last_obs), 32'h0);

        // Random traffic over a narrow register range to provoke frequent matches.
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 5));
            id_rs2        = 5'($urandom_range(0, 5));
            id_uses_rs1   = 1'($urandom);
            id_uses_rs2   = 1'($urandom);
            ex_rd         = 5'($urandom_range(0, 5));
            ex_rw         = ($urandom_range(0, 3) != 0);
            // A stall cycle always puts a bubble into EX next.
            ex_mem_read   = m_prev_lu ? 1'b0 : 1'($urandom);
            mem_req_valid = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core; the stall/flush counterpart of the forwarding unit. The forwarding unit resolves hazards by routing data; this block resolves the ones forwarding cannot: load-use (bubble), multi-cycle data-memory access (freeze), and taken branches (flush). It sits beside ID/EX and drives the enable and flush controls of the PC and all pipeline registers.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before mem_timeout sets (>=2).
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX destination register
ex_rw  in  1  EX writes rd
ex_mem_read  in  1  EX instruction is a load
mem_req_valid  in  1  MEM stage issuing a data-memory request
mem_ready  in  1  data memory completes the request this cycle
branch_taken  in  1  EX resolves a taken branch/jump
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_ex_stall  out  1  hold ID/EX
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_bubble  out  1  load NOP into MEM/WB
mem_timeout  out  1  sticky: memory did not respond within MEM_TIMEOUT

Behaviour:
- Reset: rst_n=0 sampled on a clk edge -> state=RUN, wait counter=0, mem_timeout=0. All outputs are 0 while rst_n=0 (combinational gating), including mid-stall.
- States: RUN, LU_STALL, MEM_WAIT. The state register updates on the rising edge. Outputs are combinational from state and current inputs (same-cycle effect).
- mem_hold = mem_req_valid & ~mem_ready.
- load_use = ex_mem_read & ex_rw & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority: mem_hold > branch_taken > load_use.
- mem_hold (any state): pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1, mem_wb_bubble=1; flush and bubble outputs are 0. Next state is MEM_WAIT.
- MEM_WAIT: the wait counter increments per cycle while mem_hold=1 and saturates at MEM_TIMEOUT. On reaching MEM_TIMEOUT, mem_timeout sets and stays set until reset; the stall continues. In the cycle mem_ready=1, all stalls drop and the counter clears. Next state is RUN, or LU_STALL if load_use also holds.
- branch_taken & ~mem_hold: if_id_flush=1, id_ex_bubble=1, no stalls, load_use ignored (the ID instruction is squashed). A branch held during MEM_WAIT flushes in the release cycle.
- load_use & ~branch_taken & ~mem_hold: pc_stall=if_id_stall=1, id_ex_bubble=1 for exactly one cycle. Next state is LU_STALL.
- LU_STALL: the bubble is now in EX, so load_use is false. Outputs follow the RUN rules; next state is RUN. If load_use is still true here (EX was not bubbled), the block asserts no second stall and holds an internal protocol-error flag (assertion target only).
- RUN with no condition: all outputs 0.
- x0 never causes a stall. An instruction reading the same register twice produces one bubble, not two.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles, flush_count, mem_wait_cycles, each CNT_W bits. They reset to 0 and increment on load-use stall cycles, branch flushes, and mem_hold cycles respectively. They wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX lw x5 (ex_rd=5, ex_mem_read=1, ex_rw=1), ID add x6,x5,x7 -> exactly 1 cycle of pc_stall=if_id_stall=id_ex_bubble=1, then all 0; state RUN->LU_STALL->RUN.
- x0 and non-use: EX lw x0 with ID rs1=0; also EX lw x5 with ID rs2=5 but id_uses_rs2=0 -> no stall in either case.
- Memory wait: mem_req_valid=1, mem_ready=0 for 5 cycles, then 1 -> all four stalls and mem_wb_bubble high for 5 cycles, low in the mem_ready cycle; mem_timeout stays 0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready; cleared only by rst_n=0.
- Simultaneous events: branch_taken=1 with load_use=1 -> if_id_flush=id_ex_bubble=1, pc_stall=0. Same with mem_hold=1 -> freeze only, and the flush occurs in the release cycle.
- Reset mid-stall: rst_n=0 during MEM_WAIT cycle 3 -> all outputs 0 immediately; after rst_n=1 the state is RUN and the counter is 0.
